// File: rtl/butterfly_egress.sv
// Egress stage for one butterfly switch output port.
// Checks and strips the route header, then buffers the payload in a small FIFO.
module butterfly_egress #(
  parameter int unsigned DW      = 35,
  parameter int unsigned RW      = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned CW      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_valid,
  output logic                     i_ready,
  output logic [DW-RW-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     misroute_err,
  output logic [CW-1:0]            pkt_cnt,
  output logic [CW-1:0]            drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = DW - RW;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          accept;
  logic          hdr_ok;
  logic          push;
  logic          drop;
  logic          pop;

  // Handshake decode; i_ready is registered so it never depends on o_ready.
  always_comb begin
    accept    = i_valid && i_ready;
    hdr_ok    = (i_data[DW-1 -: RW] == RW'(PORT_ID));
    push      = accept && hdr_ok;
    drop      = accept && !hdr_ok;
    pop       = o_valid && o_ready;
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  assign o_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      i_ready      <= 1'b0;
      o_valid      <= 1'b0;
      misroute_err <= 1'b0;
      pkt_cnt      <= '0;
      drop_cnt     <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_data[PW-1:0];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level   <= level_nxt;
      i_ready <= (level_nxt != LW'(DEPTH));
      o_valid <= (level_nxt != '0);
      // Statistics counters saturate rather than wrap.
      if (pop && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + CW'(1);
      end
      if (drop) begin
        misroute_err <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_butterfly_egress.sv
// Self-checking bench for butterfly_egress against a queue-based reference model.
module tb_butterfly_egress;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;
  localparam logic [2:0]  PID   = 3'd5;
  localparam int          SAT   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] i_data;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_ready;
  logic [2:0]  level;
  logic        misroute_err;
  logic [3:0]  pkt_cnt;
  logic [3:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: payload queue plus expected statistics.
  logic [31:0] q[$];
  int          m_pkt;
  int          m_drop;
  logic        m_err;
  logic        m_rdy_ok;

  butterfly_egress #(
    .DW(35), .RW(3), .DEPTH(DEPTH), .PORT_ID(5), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .level(level), .misroute_err(misroute_err),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic m_ready();
    return m_rdy_ok && (q.size() != int'(DEPTH));
  endfunction

  task automatic model_reset();
    q.delete();
    m_pkt    = 0;
    m_drop   = 0;
    m_err    = 1'b0;
    m_rdy_ok = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic drive(input logic v, input logic [31:0] pl, input logic [2:0] hdr,
                       input logic r, output logic acc);
    logic popm;
    i_valid = v;
    i_data  = {hdr, pl};
    o_ready = r;
    acc  = v && m_ready();
    popm = r && (q.size() != 0);
    @(posedge clk);
    if (popm) begin
      void'(q.pop_front());
      if (m_pkt < SAT) m_pkt++;
    end
    if (acc) begin
      if (hdr == PID) q.push_back(pl);
      else begin
        if (m_drop < SAT) m_drop++;
        m_err = 1'b1;
      end
    end
    m_rdy_ok = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; i_data = {PID, 32'h1234_5678}; o_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL reset_i_ready got=%b exp=0", i_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
    n_cmp++; if (o_data !== 32'h0) begin n_bad++; $display("FAIL reset_o_data got=%h exp=0", o_data); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (misroute_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", misroute_err); end
    n_cmp++; if (pkt_cnt !== 4'd0 || drop_cnt !== 4'd0) begin
      n_bad++; $display("FAIL reset_counters got pkt=%0d drop=%0d exp=0/0", pkt_cnt, drop_cnt);
    end
    i_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    m_rdy_ok = 1'b1;
    n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL release_i_ready got=%b exp=1", i_ready); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL release_level got=%0d exp=0", level); end
  endtask

  task automatic test_basic();
    logic acc;
    drive(1'b1, 32'hDEAD_BEEF, PID, 1'b1, acc);
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL basic_o_valid got=%b exp=1", o_valid); end
    n_cmp++; if (o_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL basic_o_data got=%h exp=deadbeef", o_data); end
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL basic_level1 got=%0d exp=1", level); end
    drive(1'b0, 32'h0, 3'd0, 1'b1, acc);
    n_cmp++; if (pkt_cnt !== 4'(m_pkt) || m_pkt != 1) begin
      n_bad++; $display("FAIL basic_pkt_cnt got=%0d exp=1", pkt_cnt);
    end
    n_cmp++; if (level !== 3'd0 || o_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_drain got level=%0d o_valid=%b exp=0/0", level, o_valid);
    end
  endtask

  task automatic test_fill_backpressure();
    logic acc;
    logic r;
    int idx = 1, cyc = 0, first_pop = -1, acc5 = -1, out_n = 0;
    while ((idx <= 5 || q.size() != 0) && cyc < 40) begin
      r = (cyc >= 6);
      if (cyc == 5) begin
        n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fill_level got=%0d exp=4", level); end
        n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL fill_i_ready got=%b exp=0", i_ready); end
      end
      if (o_valid && r) begin
        n_cmp++; if (o_data !== 32'(out_n + 1)) begin
          n_bad++; $display("FAIL fill_order got=%h exp=%h", o_data, 32'(out_n + 1));
        end
        out_n++;
        if (first_pop < 0) first_pop = cyc;
      end
      drive(idx <= 5, 32'(idx), PID, r, acc);
      if (acc) begin
        if (idx == 5) acc5 = cyc;
        idx++;
      end
      cyc++;
    end
    n_cmp++; if (out_n != 5) begin n_bad++; $display("FAIL fill_count got=%0d exp=5", out_n); end
    n_cmp++; if (acc5 != first_pop + 1) begin
      n_bad++; $display("FAIL fill_resume got=%0d exp=%0d", acc5, first_pop + 1);
    end
  endtask

  task automatic test_full_simultaneous();
    logic acc;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hA0 + 32'(i), PID, 1'b0, acc);
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL full_level got=%0d exp=4", level); end
    n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL full_i_ready got=%b exp=0", i_ready); end
    drive(1'b1, 32'hB0, PID, 1'b1, acc);
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL full_pop_level got=%0d exp=3", level); end
    n_cmp++; if (o_data !== 32'hA1) begin n_bad++; $display("FAIL full_pop_head got=%h exp=a1", o_data); end
    n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL full_resume_ready got=%b exp=1", i_ready); end
    drive(1'b1, 32'hB0, PID, 1'b1, acc);
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL full_pushpop_level got=%0d exp=3", level); end
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      n_cmp++; if (o_data !== q[0]) begin n_bad++; $display("FAIL full_drain got=%h exp=%h", o_data, q[0]); end
      drive(1'b0, 32'h0, 3'd0, 1'b1, acc);
    end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty got=%b exp=0", o_valid); end
  endtask

  task automatic test_misroute();
    logic acc;
    drive(1'b1, 32'h0000_00AA, 3'd6, 1'b1, acc);
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL misroute_not_written got=%b exp=0", o_valid); end
    drive(1'b1, 32'h0000_00BB, PID, 1'b1, acc);
    n_cmp++; if (o_data !== 32'hBB || o_valid !== 1'b1) begin
      n_bad++; $display("FAIL misroute_good got=%h/%b exp=bb/1", o_data, o_valid);
    end
    n_cmp++; if (drop_cnt !== 4'(m_drop) || m_drop != 1) begin
      n_bad++; $display("FAIL misroute_drop got=%0d exp=1", drop_cnt);
    end
    repeat (3) drive(1'b0, 32'h0, 3'd0, 1'b1, acc);
    n_cmp++; if (misroute_err !== 1'b1) begin n_bad++; $display("FAIL misroute_sticky got=%b exp=1", misroute_err); end
    n_cmp++; if (level !== 3'd0 || pkt_cnt !== 4'(m_pkt)) begin
      n_bad++; $display("FAIL misroute_only_bb got level=%0d pkt=%0d exp=0/%0d", level, pkt_cnt, m_pkt);
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hC0 + 32'(i), PID, 1'b0, acc);
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL midrst_pre_level got=%0d exp=3", level); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (o_valid !== 1'b0 || level !== 3'd0) begin
      n_bad++; $display("FAIL midrst_fifo got o_valid=%b level=%0d exp=0/0", o_valid, level);
    end
    n_cmp++; if (pkt_cnt !== 4'd0 || drop_cnt !== 4'd0 || misroute_err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_stats got pkt=%0d drop=%0d err=%b exp=0/0/0", pkt_cnt, drop_cnt, misroute_err);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 1'b0, acc);
    n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%b exp=1", i_ready); end
    drive(1'b1, 32'h5A5A_0001, PID, 1'b0, acc);
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h5A5A_0001) begin
      n_bad++; $display("FAIL midrst_latency got=%b/%h exp=1/5a5a0001", o_valid, o_data);
    end
  endtask

  task automatic test_saturation();
    logic acc;
    for (int i = 0; i < 20; i++) drive(1'b1, 32'h100 + 32'(i), PID, 1'b1, acc);
    repeat (2) drive(1'b0, 32'h0, 3'd0, 1'b1, acc);
    n_cmp++; if (pkt_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_pkt got=%0d exp=15", pkt_cnt); end
    drive(1'b1, 32'h999, PID, 1'b1, acc);
    drive(1'b0, 32'h0, 3'd0, 1'b1, acc);
    n_cmp++; if (pkt_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_hold got=%0d exp=15", pkt_cnt); end
  endtask

  task automatic test_random();
    logic acc;
    logic v, r;
    logic [2:0] hdr;
    for (int c = 0; c < 300; c++) begin
      n_cmp++; if (i_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_i_ready c=%0d got=%b exp=%b", c, i_ready, m_ready()); end
      n_cmp++; if (o_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_o_valid c=%0d got=%b", c, o_valid); end
      n_cmp++; if (level !== 3'(q.size())) begin n_bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if (o_data !== q[0]) begin n_bad++; $display("FAIL rnd_o_data c=%0d got=%h exp=%h", c, o_data, q[0]); end
      end
      n_cmp++; if (pkt_cnt !== 4'(m_pkt) || drop_cnt !== 4'(m_drop) || misroute_err !== m_err) begin
        n_bad++; $display("FAIL rnd_stats c=%0d got=%0d/%0d/%b exp=%0d/%0d/%b",
                          c, pkt_cnt, drop_cnt, misroute_err, m_pkt, m_drop, m_err);
      end
      v   = ($urandom % 4) != 0;
      hdr = (($urandom % 6) == 0) ? 3'($urandom) : PID;
      r   = ($urandom % 3) != 0;
      drive(v, $urandom, hdr, r, acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fill_backpressure();
    test_full_simultaneous();
    test_misroute();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
